// File: rtl/ad9361_spi_responder.sv
// AD9361-style 4-wire SPI responder: 16-bit instruction, 1-8 data bytes, decrementing address.
// SPI pins are oversampled on sys_clk and drive a synchronous register-file port.
`timescale 1ns/1ps

module ad9361_spi_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              spi_cs,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rdata,
    output logic              txn_done,
    output logic              txn_abort,
    output logic [15:0]       txn_cnt
);

    typedef enum logic [2:0] {StIdle, StInstr, StWdata, StRdata, StDone} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;

    logic cs_s;
    logic sclk_s;
    logic mosi_s;
    logic cs_fall;
    logic sclk_rise;
    logic sclk_fall;

    logic [14:0]       shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        bytes_left_q, bytes_left_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic [7:0]        tx_q, tx_d;
    logic              miso_oe_q, miso_oe_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              load_q;
    logic              done_q, done_d;
    logic              abort_q, abort_d;
    logic [15:0]       txn_cnt_q, txn_cnt_d;

    logic [15:0] instr_word;
    logic [7:0]  rx_byte;

    // CS chain resets high so leaving reset never looks like a CS fall.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    assign instr_word = {shift_q, mosi_s};
    assign rx_byte    = {shift_q[6:0], mosi_s};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // CS high always takes priority over an SCLK edge seen in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StInstr;
                end
            end
            StInstr: begin
                if (cs_s) begin
                    state_d = StIdle;
                end else if (sclk_rise && (bit_cnt_q == 4'd15)) begin
                    state_d = instr_word[15] ? StWdata : StRdata;
                end
            end
            StWdata, StRdata: begin
                if (cs_s) begin
                    state_d = StIdle;
                end else if (sclk_rise && (bit_cnt_q == 4'd7) && (bytes_left_q == 4'd1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (cs_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        bytes_left_d = bytes_left_q;
        addr_d       = addr_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        tx_d         = tx_q;
        miso_oe_d    = miso_oe_q;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        done_d       = 1'b0;
        abort_d      = 1'b0;
        txn_cnt_d    = txn_cnt_q;

        // Read data arrives the cycle after the strobe; present its MSB right away.
        if (load_q) begin
            tx_d      = reg_rdata;
            miso_oe_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                shift_d   = '0;
                bit_cnt_d = '0;
                miso_oe_d = 1'b0;
            end
            StInstr: begin
                if (cs_s) begin
                    abort_d = 1'b1;
                end else if (sclk_rise) begin
                    shift_d   = instr_word[14:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d    = '0;
                        addr_d       = instr_word[ADDR_W-1:0];
                        bytes_left_d = {1'b0, instr_word[14:12]} + 4'd1;
                        if (!instr_word[15]) begin
                            rd_en_d    = 1'b1;
                            reg_addr_d = instr_word[ADDR_W-1:0];
                        end
                    end
                end
            end
            StWdata: begin
                if (cs_s) begin
                    abort_d = 1'b1;
                end else if (sclk_rise) begin
                    shift_d   = instr_word[14:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d    = '0;
                        reg_wdata_d  = rx_byte;
                        reg_addr_d   = addr_q;
                        wr_en_d      = 1'b1;
                        addr_d       = addr_q - 1'b1;
                        bytes_left_d = bytes_left_q - 4'd1;
                    end
                end
            end
            StRdata: begin
                if (cs_s) begin
                    abort_d   = 1'b1;
                    miso_oe_d = 1'b0;
                end else begin
                    // The fall that opens a byte must not shift out the freshly loaded MSB.
                    if (sclk_fall && (bit_cnt_q != 4'd0)) begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (bytes_left_q == 4'd1) begin
                                miso_oe_d = 1'b0;
                            end else begin
                                addr_d       = addr_q - 1'b1;
                                reg_addr_d   = addr_q - 1'b1;
                                rd_en_d      = 1'b1;
                                bytes_left_d = bytes_left_q - 4'd1;
                            end
                        end
                    end
                end
            end
            StDone: begin
                miso_oe_d = 1'b0;
                if (cs_s) begin
                    done_d    = 1'b1;
                    txn_cnt_d = txn_cnt_q + 16'd1;
                end
            end
            default: begin
                miso_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            bytes_left_q <= '0;
            addr_q       <= '0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            tx_q         <= '0;
            miso_oe_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            load_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            txn_cnt_q    <= '0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            bytes_left_q <= bytes_left_d;
            addr_q       <= addr_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            tx_q         <= tx_d;
            miso_oe_q    <= miso_oe_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            load_q       <= rd_en_q;
            done_q       <= done_d;
            abort_q      <= abort_d;
            txn_cnt_q    <= txn_cnt_d;
        end
    end

    always_comb begin
        spi_miso_oe = miso_oe_q;
        spi_miso    = miso_oe_q & tx_q[7];
        reg_addr    = reg_addr_q;
        reg_wdata   = reg_wdata_q;
        reg_wr_en   = wr_en_q;
        reg_rd_en   = rd_en_q;
        txn_done    = done_q;
        txn_abort   = abort_q;
        txn_cnt     = txn_cnt_q;
    end

endmodule

// File: doc/ad9361_spi_responder.md
Name: ad9361_spi_responder

Overview:
Synthesizable SPI responder that implements the AD9361 4-wire SPI protocol: 16-bit instruction word, then 1-8 data bytes, with the address auto-decrementing after each byte. It is the target-side counterpart of the AD9361 SPI initiator. It is used in on-board loopback tests and in the simulation model of the transceiver. Internally it oversamples SPI pins on sys_clk and drives a simple synchronous register-file port.

Parameters:
ADDR_W, 10, register address width (instruction bits [9:0])
SYNC_STAGES, 2, synchronizer depth on spi_cs/spi_sclk/spi_mosi (minimum 2)

Ports:
sys_clk  in  1  system clock; SCLK frequency must not exceed sys_clk/8
sys_rst_n  in  1  asynchronous active-low reset
spi_cs  in  1  chip select, active-low
spi_sclk  in  1  SPI clock, idle low; MOSI sampled on rising edge, MISO changes on falling edge
spi_mosi  in  1  serial data in, MSB first
spi_miso  out  1  serial data out, MSB first
spi_miso_oe  out  1  MISO output enable (high only during read data phase)
reg_addr  out  ADDR_W  register address
reg_wdata  out  8  write data
reg_wr_en  out  1  one-cycle write strobe
reg_rd_en  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid exactly 1 cycle after reg_rd_en
txn_done  out  1  one-cycle pulse when a transaction completes with all bytes
txn_abort  out  1  one-cycle pulse when CS deasserts early or mid-byte
txn_cnt  out  16  count of completed transactions, wraps at 0xFFFF->0

Behaviour:
- Reset: all outputs 0, reg_addr 0, txn_cnt 0, FSM in IDLE.
- Edge detection: sync all three inputs; rise/fall = registered compare of synced SCLK. CS low is qualified on the synced CS value.
- Instruction format: bit15 = 1 write / 0 read; bits[14:12] = NB, byte count = NB+1; bits[11:10] ignored; bits[9:0] = start address.
- FSM:
  - IDLE -> INSTR on synced CS falling.
  - INSTR: shift 16 bits on SCLK rises. At the 16th rise, load addr and byte counter, then go to WDATA or RDATA.
  - WDATA: after each 8th rise, reg_wdata = byte and reg_addr = current addr, with reg_wr_en pulsed the next cycle. Then addr -= 1 and remaining -= 1. At remaining 0 -> DONE.
  - RDATA: reg_rd_en pulses on the cycle after the 16th instruction rise (first byte), and after the 8th rise of each non-final byte (next addr). reg_rdata is latched into the TX shift register the following cycle. spi_miso_oe = 1 and the MSB is presented before the next SCLK fall; subsequent bits shift on falls. After the final byte's 8th rise -> DONE.
  - DONE: ignore SCLK; spi_miso = 0, oe = 0. Go to IDLE on CS high with a txn_done pulse and txn_cnt += 1.
- Address arithmetic: ADDR_W-bit decrement that wraps 0x000 -> 0x3FF.
- CS high in INSTR/WDATA/RDATA -> IDLE with a txn_abort pulse. A partial byte is discarded and no write occurs for it; completed bytes are already written. txn_cnt is unchanged.
- CS high and an SCLK edge in the same cycle: CS wins and the edge is ignored.
- SCLK pulses while CS is high: ignored.
- Asserting reset mid-transaction returns to IDLE immediately with no strobes.
- reg_wr_en and reg_rd_en are never high in the same cycle.

Test Plan:
1. Single write: instr 0x8015, data 0xA5 -> exactly one reg_wr_en with addr 0x015 and wdata 0xA5; txn_done pulse; txn_cnt = 1.
2. Burst write: instr 0xB0FF (NB=3), data 0x11,0x22,0x33,0x44 -> writes to 0x0FF=0x11, 0x0FE=0x22, 0x0FD=0x33, 0x0FC=0x44; four strobes total.
3. Single read: instr 0x0037 with bench returning 0x0A -> MISO shifts 0x0A; oe high for exactly 8 SCLK periods; reg_rd_en for addr 0x037 only.
4. Burst read with address wrap: instr 0x1001 (NB=1) -> reads addr 0x001 then 0x000. Instr 0x1000 -> reads 0x000 then 0x3FF; MISO bytes match the bench model.
5. Abort: instr 0x8020, then CS high after 5 data bits -> no reg_wr_en; txn_abort pulse; txn_cnt unchanged; the next full transaction succeeds.
6. Reset mid-burst: assert sys_rst_n low during byte 2 of a write -> outputs are zero asynchronously; after release the FSM is in IDLE and a fresh 0x8015 write works.
